mul_sequencer: RTL and testbench

- Multi-cycle controller that runs RV32M MUL (low XLEN bits of the product) on the shared EX-stage ALU, using repeated ALU adds (shift-add).
- Accepts a request from EX and stalls the pipeline while it owns the ALU.
- Drives ALU operands and the 4-bit ALU control code itself, then returns the product for the EX/MEM register.
- Sits beside the ALU-control decoder. `alu_sel_o` steers the ALU input muxes between the decoder path and this block.

---
 rtl/alu_pkg.sv | 16 +
 rtl/mul_sequencer_if.sv | 31 +++
 rtl/mul_shift_regs.sv | 44 ++++
 rtl/mul_sequencer.sv | 105 ++++++++++
 tb/tb_mul_sequencer.sv | 256 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU control codes and the MUL sequencer state encoding.
// The ALU-control decoder imports the same constants so both ALU input paths agree.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mul_state_t;

endpackage

// File: rtl/mul_sequencer_if.sv
// EX-stage request, ALU borrow and result signals of the MUL sequencer.
// The master modport is the EX stage / ALU side; the slave modport is the sequencer.
interface mul_sequencer_if #(
  parameter int XLEN = 32
);

  logic            start_i;
  logic [XLEN-1:0] rs1_i;
  logic [XLEN-1:0] rs2_i;
  logic            flush_i;
  logic            ready_o;
  logic            stall_o;
  logic            alu_sel_o;
  logic [XLEN-1:0] alu_a_o;
  logic [XLEN-1:0] alu_b_o;
  logic [3:0]      alu_ctrl_o;
  logic [XLEN-1:0] alu_result_i;
  logic            done_o;
  logic [XLEN-1:0] product_o;

  modport master (
    output start_i, rs1_i, rs2_i, flush_i, alu_result_i,
    input  ready_o, stall_o, alu_sel_o, alu_a_o, alu_b_o, alu_ctrl_o, done_o, product_o
  );

  modport slave (
    input  start_i, rs1_i, rs2_i, flush_i, alu_result_i,
    output ready_o, stall_o, alu_sel_o, alu_a_o, alu_b_o, alu_ctrl_o, done_o, product_o
  );

endinterface

// File: rtl/mul_shift_regs.sv
// Shift-add datapath registers for the MUL sequencer: accumulator, shifted
// multiplicand, shifted multiplier and iteration count, with load/step/hold.
module mul_shift_regs #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [XLEN-1:0]  rs1,
  input  logic [XLEN-1:0]  rs2,
  input  logic [XLEN-1:0]  alu_result,
  output logic [XLEN-1:0]  acc,
  output logic [XLEN-1:0]  mcand,
  output logic [XLEN-1:0]  mplier,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      cnt    <= '0;
    end else if (load) begin
      acc    <= '0;
      mcand  <= rs1;
      mplier <= rs2;
      cnt    <= '0;
    end else if (step) begin
      // The ALU is computing acc + mcand this cycle; commit it only for a set multiplier bit.
      if (mplier[0]) acc <= alu_result;
      mcand  <= {mcand[XLEN-2:0], 1'b0};
      mplier <= {1'b0, mplier[XLEN-1:1]};
      cnt    <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) assert (cnt <= CNT_W'(XLEN));
  end

endmodule

// File: rtl/mul_sequencer.sv
// RV32M MUL controller: borrows the EX-stage ALU for shift-add iterations,
// stalls the pipeline while it owns the ALU, and returns the low product word.
module mul_sequencer
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input logic           clk,
  input logic           rst_n,
  mul_sequencer_if.slave bus
);

  mul_state_t       state, state_nxt;
  logic [XLEN-1:0]  acc, mcand, mplier;
  logic [CNT_W-1:0] cnt;
  logic             load, step, finish;
  logic [XLEN-1:0]  product;

  logic             ready, stall, alu_sel, done;
  logic [XLEN-1:0]  alu_a, alu_b;
  logic [3:0]       alu_ctrl;

  mul_shift_regs #(
    .XLEN (XLEN),
    .CNT_W(CNT_W)
  ) u_regs (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .step      (step),
    .rs1       (bus.rs1_i),
    .rs2       (bus.rs2_i),
    .alu_result(bus.alu_result_i),
    .acc       (acc),
    .mcand     (mcand),
    .mplier    (mplier),
    .cnt       (cnt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      product <= '0;
    end else begin
      state <= state_nxt;
      if (finish) product <= acc;
    end
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    stall     = 1'b0;
    alu_sel   = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_ctrl  = ALU_AND;
    done      = 1'b0;
    load      = 1'b0;
    step      = 1'b0;
    finish    = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.start_i && !bus.flush_i) begin
          load      = 1'b1;
          stall     = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        alu_sel  = 1'b1;
        alu_ctrl = ALU_ADD;
        alu_a    = acc;
        alu_b    = mcand;
        stall    = !bus.flush_i;
        if (bus.flush_i) begin
          state_nxt = IDLE;
        end else if (mplier == '0 || cnt == CNT_W'(XLEN)) begin
          finish    = 1'b1;
          state_nxt = DONE;
        end else begin
          step = 1'b1;
        end
      end
      DONE: begin
        // A flush in this cycle kills the result handoff to EX/MEM.
        done      = !bus.flush_i;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.ready_o    = ready;
  assign bus.stall_o    = stall;
  assign bus.alu_sel_o  = alu_sel;
  assign bus.alu_a_o    = alu_a;
  assign bus.alu_b_o    = alu_b;
  assign bus.alu_ctrl_o = alu_ctrl;
  assign bus.done_o     = done;
  assign bus.product_o  = product;

endmodule

// File: tb/tb_mul_sequencer.sv
// Bench for mul_sequencer: ALU model on the borrowed ALU port, table vectors,
// random operands against an arithmetic reference, and handshake corner sequences.
module tb_mul_sequencer;
  import alu_pkg::*;

  localparam int XLEN = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  mul_sequencer_if #(.XLEN(XLEN)) bus ();

  mul_sequencer #(
    .XLEN (XLEN),
    .CNT_W(6)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Behavioural ALU shared with the decoder path.
  always_comb begin
    case (bus.alu_ctrl_o)
      ALU_ADD: bus.alu_result_i = bus.alu_a_o + bus.alu_b_o;
      ALU_SUB: bus.alu_result_i = bus.alu_a_o - bus.alu_b_o;
      ALU_AND: bus.alu_result_i = bus.alu_a_o & bus.alu_b_o;
      ALU_OR:  bus.alu_result_i = bus.alu_a_o | bus.alu_b_o;
      default: bus.alu_result_i = '0;
    endcase
  end

  typedef struct {
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] prod;
    int          lat;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_prod(input logic [31:0] a, input logic [31:0] b);
    return a * b;
  endfunction

  function automatic int model_lat(input logic [31:0] b);
    int m;
    if (b == 0) return 2;
    m = 0;
    for (int i = 0; i < 32; i++) if (b[i]) m = i;
    return m + 3;
  endfunction

  // Entered just after a rising edge with the DUT idle; returns likewise.
  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_p, input int exp_lat);
    int bad;
    bit seen;
    bad  = 0;
    seen = 0;
    bus.rs1_i   = a;
    bus.rs2_i   = b;
    bus.start_i = 1'b1;
    @(negedge clk);
    check({name, " accept_stall"}, 32'(bus.stall_o), 32'd1);
    check({name, " accept_ready"}, 32'(bus.ready_o), 32'd1);
    for (int k = 1; k <= XLEN + 8 && !seen; k++) begin
      @(posedge clk);
      #1;
      bus.start_i = 1'b0;
      @(negedge clk);
      if (bus.done_o) begin
        seen = 1;
        check({name, " latency"}, 32'(k), 32'(exp_lat));
        check({name, " product"}, bus.product_o, exp_p);
        check({name, " done_stall"}, 32'(bus.stall_o), 32'd0);
        check({name, " done_ready"}, 32'(bus.ready_o), 32'd0);
      end else begin
        if (!bus.alu_sel_o || bus.alu_ctrl_o != ALU_ADD || !bus.stall_o || bus.ready_o) bad++;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no done_o within %0d cycles, expected at cycle %0d",
               name, XLEN + 8, exp_lat);
    end
    check({name, " busy_ctrl_violations"}, 32'(bad), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b, prev;
    int          n;

    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.rs1_i   = '0;
    bus.rs2_i   = '0;

    tbl[0] = '{rs1: 32'd6,         rs2: 32'd7,         prod: 32'd42,        lat: 5};
    tbl[1] = '{rs1: 32'h0000_1234, rs2: 32'd0,         prod: 32'd0,         lat: 2};
    tbl[2] = '{rs1: 32'hFFFF_FFFF, rs2: 32'hFFFF_FFFF, prod: 32'h0000_0001, lat: 34};
    tbl[3] = '{rs1: 32'd3,         rs2: 32'h8000_0000, prod: 32'h8000_0000, lat: 34};
    tbl[4] = '{rs1: 32'd5,         rs2: 32'd5,         prod: 32'd25,        lat: 5};
    tbl[5] = '{rs1: 32'd1,         rs2: 32'd1,         prod: 32'd1,         lat: 3};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst ready", 32'(bus.ready_o), 32'd1);
    check("rst stall", 32'(bus.stall_o), 32'd0);
    check("rst alu_sel", 32'(bus.alu_sel_o), 32'd0);
    check("rst alu_ctrl", 32'(bus.alu_ctrl_o), 32'd0);
    check("rst alu_a", bus.alu_a_o, 32'd0);
    check("rst alu_b", bus.alu_b_o, 32'd0);
    check("rst done", 32'(bus.done_o), 32'd0);
    check("rst product", bus.product_o, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++)
      run_op($sformatf("vec%0d", i), tbl[i].rs1, tbl[i].rs2, tbl[i].prod, tbl[i].lat);

    for (int i = 0; i < 24; i++) begin
      a = $urandom;
      b = $urandom >> $urandom_range(31, 0);
      run_op($sformatf("rnd%0d", i), a, b, model_prod(a, b), model_lat(b));
    end

    // Flush mid-operation
    prev = bus.product_o;
    bus.rs1_i = 32'd100;
    bus.rs2_i = 32'd100;
    bus.start_i = 1'b1;
    @(posedge clk); #1; bus.start_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1; bus.flush_i = 1'b1;
    @(negedge clk);
    check("flush cyc3 stall", 32'(bus.stall_o), 32'd0);
    check("flush cyc3 done", 32'(bus.done_o), 32'd0);
    @(posedge clk); #1; bus.flush_i = 1'b0;
    @(negedge clk);
    check("flush cyc4 ready", 32'(bus.ready_o), 32'd1);
    check("flush cyc4 stall", 32'(bus.stall_o), 32'd0);
    check("flush cyc4 alu_sel", 32'(bus.alu_sel_o), 32'd0);
    check("flush cyc4 product", bus.product_o, prev);
    n = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done_o) n++;
    end
    check("flush no_done", 32'(n), 32'd0);
    @(posedge clk); #1;

    // Flush during DONE suppresses the pulse
    bus.rs1_i = 32'd5;
    bus.rs2_i = 32'd0;
    bus.start_i = 1'b1;
    @(posedge clk); #1; bus.start_i = 1'b0;
    @(posedge clk); #1; bus.flush_i = 1'b1;
    @(negedge clk);
    check("flush_done done", 32'(bus.done_o), 32'd0);
    check("flush_done stall", 32'(bus.stall_o), 32'd0);
    @(posedge clk); #1; bus.flush_i = 1'b0;
    @(negedge clk);
    check("flush_done ready", 32'(bus.ready_o), 32'd1);
    @(posedge clk); #1;

    // Reset in the middle of a long operation
    bus.rs1_i = 32'hFFFF_FFFF;
    bus.rs2_i = 32'hFFFF_FFFF;
    bus.start_i = 1'b1;
    @(posedge clk); #1; bus.start_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    @(negedge clk);
    check("midrst ready", 32'(bus.ready_o), 32'd1);
    check("midrst stall", 32'(bus.stall_o), 32'd0);
    check("midrst alu_sel", 32'(bus.alu_sel_o), 32'd0);
    check("midrst alu_ctrl", 32'(bus.alu_ctrl_o), 32'd0);
    check("midrst done", 32'(bus.done_o), 32'd0);
    check("midrst product", bus.product_o, 32'd0);
    @(posedge clk); #1;
    run_op("post_rst 5x5", 32'd5, 32'd5, 32'd25, 5);

    // start_i held high: one accept per op, next accept right after DONE
    bus.rs1_i = 32'd7;
    bus.rs2_i = 32'd3;
    bus.start_i = 1'b1;
    @(negedge clk);
    check("held accept0 stall", 32'(bus.stall_o), 32'd1);
    for (int c = 1; c <= 11; c++) begin
      @(posedge clk);
      #1;
      if (c == 1) begin
        bus.rs1_i = 32'd9;
        bus.rs2_i = 32'd2;
      end
      if (c == 6) bus.start_i = 1'b0;
      @(negedge clk);
      check($sformatf("held c%0d done", c), 32'(bus.done_o), 32'((c == 4) || (c == 9)));
      check($sformatf("held c%0d ready", c), 32'(bus.ready_o),
            32'((c == 5) || (c == 10) || (c == 11)));
      if (c == 4) check("held opA product", bus.product_o, 32'd21);
      if (c == 9) check("held opB product", bus.product_o, 32'd18);
    end
    @(posedge clk); #1;

    // start and flush together while idle: no accept
    bus.rs1_i = 32'd11;
    bus.rs2_i = 32'd13;
    bus.start_i = 1'b1;
    bus.flush_i = 1'b1;
    @(negedge clk);
    check("start_flush stall", 32'(bus.stall_o), 32'd0);
    check("start_flush ready", 32'(bus.ready_o), 32'd1);
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    bus.flush_i = 1'b0;
    @(negedge clk);
    check("start_flush idle ready", 32'(bus.ready_o), 32'd1);
    check("start_flush idle alu_sel", 32'(bus.alu_sel_o), 32'd0);
    @(posedge clk); #1;
    run_op("after start_flush 11x13", 32'd11, 32'd13, 32'd143, 6);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
